// File: rtl/fwd_hazard_unit.sv
// Purpose : operand forwarding selects and load-use stall for the integer pipeline.
// Latency : stall_o is combinational from ID; forwarding selects are registered and
//           reach EX together with the instruction, one cycle after ID.
// Backpr. : stall_o holds ID/IF and puts a bubble into EX. hold_i freezes every register.
//
// Ports:
//   clk, reset        single clock; synchronous active-high reset
//   hold_i            pipeline freeze: scoreboard and EX outputs keep their values
//   flush_i           kill the instruction in ID; it enters EX as a bubble
//   id_valid_i        ID holds a real instruction
//   id_rs_i           NUM_SRC source addresses; operand k at [k*REG_AW +: REG_AW]
//   id_rd_i           destination address
//   id_regwrite_i     instruction writes rd
//   id_memread_i      instruction is a load
//   stall_o           load-use stall for the instruction in ID
//   ex_valid_o        EX holds an issued instruction
//   ex_fwd_sel_o      per-operand select: 0 = register file, s = stage-s result
module fwd_hazard_unit #(
    parameter  int REG_AW   = 5,
    parameter  int NUM_SRC  = 2,
    parameter  int DEPTH    = 2,
    parameter  int LOAD_LAT = 1,
    localparam int SELW     = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hold_i,
    input  logic                      flush_i,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0]         id_rd_i,
    input  logic                      id_regwrite_i,
    input  logic                      id_memread_i,
    output logic                      stall_o,
    output logic                      ex_valid_o,
    output logic [NUM_SRC*SELW-1:0]   ex_fwd_sel_o
);

    // Scoreboard entries 0..DEPTH-1 (0 = EX). The oldest stage is covered by the
    // writeback-before-read register file and can never be matched, so it is not stored.
    logic [DEPTH-1:0]  sb_vld;
    logic [DEPTH-1:0]  sb_wr;
    logic [DEPTH-1:0]  sb_ld;
    logic [REG_AW-1:0] sb_rd [DEPTH];

    logic [NUM_SRC*SELW-1:0] sel_nxt;
    logic [NUM_SRC-1:0]      haz;
    logic                    issue;

    // Walk from the oldest stage to the youngest so that the youngest producer
    // overwrites any older match. A write to x0 is never recorded as a producer
    // (sb_wr is cleared), so an rs of 0 can never match.
    always_comb begin
        sel_nxt = '0;
        haz     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            for (int s = DEPTH - 1; s >= 0; s--) begin
                if (sb_vld[s] && sb_wr[s] &&
                    (sb_rd[s] == id_rs_i[k*REG_AW +: REG_AW])) begin
                    sel_nxt[k*SELW +: SELW] = SELW'(s + 1);
                    // Load data is not available yet while the load sits in
                    // stages 0..LOAD_LAT-1.
                    haz[k] = sb_ld[s] && (s < LOAD_LAT);
                end
            end
        end
    end

    // Flush outranks the stall: a killed instruction has no hazard.
    assign stall_o = id_valid_i && !flush_i && (|haz);
    assign issue   = id_valid_i && !flush_i && !(|haz);

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_vld       <= '0;
            sb_wr        <= '0;
            sb_ld        <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                sb_rd[s] <= '0;
            end
            ex_valid_o   <= 1'b0;
            ex_fwd_sel_o <= '0;
        end else if (!hold_i) begin
            // Stages ahead of EX always advance, even while ID is stalled.
            for (int s = DEPTH - 1; s > 0; s--) begin
                sb_vld[s] <= sb_vld[s-1];
                sb_wr[s]  <= sb_wr[s-1];
                sb_ld[s]  <= sb_ld[s-1];
                sb_rd[s]  <= sb_rd[s-1];
            end
            // A non-issue cycle inserts a bubble: only the valid bit matters.
            sb_vld[0]    <= issue;
            sb_wr[0]     <= id_regwrite_i && (id_rd_i != '0);
            sb_ld[0]     <= id_memread_i;
            sb_rd[0]     <= id_rd_i;
            ex_valid_o   <= issue;
            ex_fwd_sel_o <= issue ? sel_nxt : '0;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit with DEPTH=2, LOAD_LAT=1, NUM_SRC=2.
// Each step drives ID/control for one cycle, checks the combinational stall,
// then compares the registered EX outputs against the queued expectation.
module tb_fwd_hazard_unit;

    localparam int REG_AW   = 5;
    localparam int NUM_SRC  = 2;
    localparam int DEPTH    = 2;
    localparam int LOAD_LAT = 1;
    localparam int SELW     = 2;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      hold_i;
    logic                      flush_i;
    logic                      id_valid_i;
    logic [NUM_SRC*REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0]         id_rd_i;
    logic                      id_regwrite_i;
    logic                      id_memread_i;
    logic                      stall_o;
    logic                      ex_valid_o;
    logic [NUM_SRC*SELW-1:0]   ex_fwd_sel_o;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .REG_AW  (REG_AW),
        .NUM_SRC (NUM_SRC),
        .DEPTH   (DEPTH),
        .LOAD_LAT(LOAD_LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hold_i       (hold_i),
        .flush_i      (flush_i),
        .id_valid_i   (id_valid_i),
        .id_rs_i      (id_rs_i),
        .id_rd_i      (id_rd_i),
        .id_regwrite_i(id_regwrite_i),
        .id_memread_i (id_memread_i),
        .stall_o      (stall_o),
        .ex_valid_o   (ex_valid_o),
        .ex_fwd_sel_o (ex_fwd_sel_o)
    );

    typedef struct {
        bit       rst, hd, fl, v;
        bit [4:0] rs1, rs2, rd;
        bit       rw, mr;
        bit       st;        // expected stall_o during this cycle
        bit       exv;       // expected ex_valid_o after the edge
        bit [1:0] s1, s2;    // expected selects after the edge
    } step_t;

    typedef struct {
        bit       exv;
        bit [3:0] sel;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic step_t mk(input bit rst, input bit hd, input bit fl, input bit v,
                                 input int rs1, input int rs2, input int rd,
                                 input bit rw, input bit mr, input bit st,
                                 input bit exv, input int s1, input int s2);
        step_t s;
        s.rst = rst; s.hd = hd; s.fl = fl; s.v = v;
        s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd);
        s.rw = rw; s.mr = mr; s.st = st; s.exv = exv;
        s.s1 = 2'(s1); s.s2 = 2'(s2);
        return s;
    endfunction

    // Drive one cycle of stimulus and queue the EX outputs it must produce.
    task automatic apply(input step_t s);
        exp_t e;
        reset         = s.rst;
        hold_i        = s.hd;
        flush_i       = s.fl;
        id_valid_i    = s.v;
        id_rs_i       = {s.rs2, s.rs1};
        id_rd_i       = s.rd;
        id_regwrite_i = s.rw;
        id_memread_i  = s.mr;
        e.exv         = s.exv;
        e.sel         = {s.s2, s.s1};
        q.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1; hold_i = 1'b0; flush_i = 1'b0; id_valid_i = 1'b0;
        id_rs_i = '0; id_rd_i = '0; id_regwrite_i = 1'b0; id_memread_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0, 0,0,0));
        st.push_back(mk(0,0,0,1, 1,2,5, 1,0, 0, 1,0,0));
        st.push_back(mk(0,0,0,1, 5,5,6, 1,0, 0, 1,1,1));
        // Reset outranks hold.
        st.push_back(mk(1,1,0,1, 6,5,7, 1,0, 0, 0,0,0));
        st.push_back(mk(0,0,0,1, 6,5,8, 1,0, 0, 1,0,0));
        foreach (st[i]) begin
            apply(st[i]);
            #2;
            checks++;
            if (stall_o !== st[i].st) begin
                errors++;
                $display("FAIL reset.stall step %0d: got %b want %b", i, stall_o, st[i].st);
            end
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if (ex_valid_o !== e.exv || ex_fwd_sel_o !== e.sel) begin
                errors++;
                $display("FAIL reset.ex step %0d: got v=%b sel=%h want v=%b sel=%h",
                         i, ex_valid_o, ex_fwd_sel_o, e.exv, e.sel);
            end
        end
    endtask

    task automatic test_fwd_ex();
        step_t st[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(0,0,0,1, 1,2,5, 1,0, 0, 1,0,0));  // add x5 <- x1,x2
        st.push_back(mk(0,0,0,1, 5,6,7, 1,0, 0, 1,1,0));  // add x7 <- x5,x6
        st.push_back(mk(0,0,0,1, 6,7,8, 1,0, 0, 1,0,1));  // rs2 = x7 from EX
        st.push_back(mk(0,0,0,0, 0,0,0, 0,0, 0, 0,0,0));  // bubble
        foreach (st[i]) begin
            apply(st[i]);
            #2;
            checks++;
            if (stall_o !== st[i].st) begin
                errors++;
                $display("FAIL fwd_ex.stall step %0d: got %b want %b", i, stall_o, st[i].st);
            end
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if (ex_valid_o !== e.exv || ex_fwd_sel_o !== e.sel) begin
                errors++;
                $display("FAIL fwd_ex.ex step %0d: got v=%b sel=%h want v=%b sel=%h",
                         i, ex_valid_o, ex_fwd_sel_o, e.exv, e.sel);
            end
        end
    endtask

    task automatic test_fwd_mem();
        step_t st[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(0,0,0,1, 1,2,5,  1,0, 0, 1,0,0));  // add x5
        st.push_back(mk(0,0,0,1, 3,4,8,  1,0, 0, 1,0,0));  // add x8 (independent)
        st.push_back(mk(0,0,0,1, 5,8,9,  1,0, 0, 1,2,1));  // x5 from stage 2, x8 from stage 1
        st.push_back(mk(0,0,0,1, 0,0,10, 1,0, 0, 1,0,0));  // gap
        st.push_back(mk(0,0,0,1, 5,6,11, 1,0, 0, 1,0,0));  // x5 out of forwarding range
        foreach (st[i]) begin
            apply(st[i]);
            #2;
            checks++;
            if (stall_o !== st[i].st) begin
                errors++;
                $display("FAIL fwd_mem.stall step %0d: got %b want %b", i, stall_o, st[i].st);
            end
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if (ex_valid_o !== e.exv || ex_fwd_sel_o !== e.sel) begin
                errors++;
                $display("FAIL fwd_mem.ex step %0d: got v=%b sel=%h want v=%b sel=%h",
                         i, ex_valid_o, ex_fwd_sel_o, e.exv, e.sel);
            end
        end
    endtask

    task automatic test_load_use();
        step_t st[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(0,0,0,1, 1,0,5, 1,1, 0, 1,0,0));  // lw x5
        st.push_back(mk(0,0,0,1, 5,2,6, 1,0, 1, 0,0,0));  // add <- x5 stalls, bubble
        st.push_back(mk(0,0,0,1, 5,2,6, 1,0, 0, 1,2,0));  // issues with sel 2
        st.push_back(mk(0,0,0,1, 1,0,7, 1,1, 0, 1,0,0));  // lw x7
        st.push_back(mk(0,0,0,1, 3,0,8, 1,0, 0, 1,0,0));  // independent
        st.push_back(mk(0,0,0,1, 4,7,9, 1,0, 0, 1,0,2));  // load two back: no stall
        foreach (st[i]) begin
            apply(st[i]);
            #2;
            checks++;
            if (stall_o !== st[i].st) begin
                errors++;
                $display("FAIL load_use.stall step %0d: got %b want %b", i, stall_o, st[i].st);
            end
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if (ex_valid_o !== e.exv || ex_fwd_sel_o !== e.sel) begin
                errors++;
                $display("FAIL load_use.ex step %0d: got v=%b sel=%h want v=%b sel=%h",
                         i, ex_valid_o, ex_fwd_sel_o, e.exv, e.sel);
            end
        end
    endtask

    task automatic test_youngest_x0();
        step_t st[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(0,0,0,1, 1,2,5, 1,0, 0, 1,0,0));  // add x5 (older)
        st.push_back(mk(0,0,0,1, 3,4,5, 1,0, 0, 1,0,0));  // add x5 (younger)
        st.push_back(mk(0,0,0,1, 5,5,6, 1,0, 0, 1,1,1));  // youngest wins
        st.push_back(mk(0,0,0,1, 1,2,0, 1,0, 0, 1,0,0));  // write to x0
        st.push_back(mk(0,0,0,1, 0,0,7, 1,0, 0, 1,0,0));  // read x0: no forward
        st.push_back(mk(0,0,0,1, 1,2,9, 0,0, 0, 1,0,0));  // rd=x9 but no regwrite
        st.push_back(mk(0,0,0,1, 9,9,3, 1,0, 0, 1,0,0));  // x9 not a producer
        foreach (st[i]) begin
            apply(st[i]);
            #2;
            checks++;
            if (stall_o !== st[i].st) begin
                errors++;
                $display("FAIL youngest.stall step %0d: got %b want %b", i, stall_o, st[i].st);
            end
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if (ex_valid_o !== e.exv || ex_fwd_sel_o !== e.sel) begin
                errors++;
                $display("FAIL youngest.ex step %0d: got v=%b sel=%h want v=%b sel=%h",
                         i, ex_valid_o, ex_fwd_sel_o, e.exv, e.sel);
            end
        end
    endtask

    task automatic test_hold();
        step_t st[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(0,0,0,1, 1,2,5, 1,0, 0, 1,0,0));  // add x5
        st.push_back(mk(0,0,0,1, 5,0,5, 1,1, 0, 1,1,0));  // lw x5 <- x5, sel 1
        for (int h = 0; h < 3; h++)                        // frozen: EX keeps lw outputs
            st.push_back(mk(0,1,0,1, 5,2,6, 1,0, 1, 1,1,0));
        st.push_back(mk(0,0,0,1, 5,2,6, 1,0, 1, 0,0,0));  // first normal cycle: bubble
        st.push_back(mk(0,0,0,1, 5,2,6, 1,0, 0, 1,2,0));  // resolved
        foreach (st[i]) begin
            apply(st[i]);
            #2;
            checks++;
            if (stall_o !== st[i].st) begin
                errors++;
                $display("FAIL hold.stall step %0d: got %b want %b", i, stall_o, st[i].st);
            end
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if (ex_valid_o !== e.exv || ex_fwd_sel_o !== e.sel) begin
                errors++;
                $display("FAIL hold.ex step %0d: got v=%b sel=%h want v=%b sel=%h",
                         i, ex_valid_o, ex_fwd_sel_o, e.exv, e.sel);
            end
        end
    endtask

    task automatic test_flush_reset();
        step_t st[$];
        exp_t  e;
        do_reset();
        st.push_back(mk(0,0,0,1, 1,0,5, 1,1, 0, 1,0,0));  // lw x5
        st.push_back(mk(0,0,1,1, 5,2,6, 1,0, 0, 0,0,0));  // flush beats stall
        st.push_back(mk(0,0,0,1, 5,2,6, 1,0, 0, 1,2,0));
        st.push_back(mk(0,0,0,1, 1,0,5, 1,1, 0, 1,0,0));  // lw x5 again
        st.push_back(mk(1,0,0,1, 5,2,6, 1,0, 1, 0,0,0));  // reset while stalled
        st.push_back(mk(0,0,0,1, 5,2,6, 1,0, 0, 1,0,0));  // scoreboard empty
        foreach (st[i]) begin
            apply(st[i]);
            #2;
            checks++;
            if (stall_o !== st[i].st) begin
                errors++;
                $display("FAIL flush_reset.stall step %0d: got %b want %b", i, stall_o, st[i].st);
            end
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if (ex_valid_o !== e.exv || ex_fwd_sel_o !== e.sel) begin
                errors++;
                $display("FAIL flush_reset.ex step %0d: got v=%b sel=%h want v=%b sel=%h",
                         i, ex_valid_o, ex_fwd_sel_o, e.exv, e.sel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fwd_ex();
        test_fwd_mem();
        test_load_use();
        test_youngest_x0();
        test_hold();
        test_flush_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
